// File: rtl/csr_irq_pkg.sv
// csr_irq_pkg: shared constants for the machine-mode CSR file and interrupt controller.
//   - CSR addresses, funct3 CSR command codes, mstatus bit positions
//   - interrupt bit base within mie/mip and the interrupt flag of mcause
//   - CSR op decode helper
package csr_irq_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;
   localparam int unsigned IRQ_BIT_BASE = 16;

   localparam logic [31:0] CAUSE_INTR_MSB   = 32'h8000_0000;
   // MPP is hard-wired to machine mode
   localparam logic [31:0] MSTATUS_MPP_BITS = 32'h0000_1800;

   typedef enum logic [1:0] {
      CsrOpNone,
      CsrOpWrite,
      CsrOpSet,
      CsrOpClear
   } csr_op_e;

   // Register and immediate forms share the same operation.
   function automatic csr_op_e decode_op(input logic [2:0] funct3);
      csr_op_e op;
      case (funct3)
         F3_CSRRW, F3_CSRRWI: op = CsrOpWrite;
         F3_CSRRS, F3_CSRRSI: op = CsrOpSet;
         F3_CSRRC, F3_CSRRCI: op = CsrOpClear;
         default:             op = CsrOpNone;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/irq_arbiter.sv
// irq_arbiter: combinational fixed-priority encoder, lowest index wins.
//   active : per-line request vector (pending & enabled)
//   valid  : at least one line active
//   index  : index of the winning line (0 when none)
module irq_arbiter
   import csr_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 4
) (
   input  logic [NUM_IRQ-1:0] active,
   output logic               valid,
   output logic [3:0]         index
);

   always_comb begin
      valid = 1'b0;
      index = '0;
      // Scan downwards so the lowest active line is assigned last.
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (active[i]) begin
            valid = 1'b1;
            index = 4'(i);
         end
      end
   end

endmodule

// File: rtl/csr_irq_unit.sv
// csr_irq_unit: machine-mode CSR file with an edge-triggered multi-line interrupt controller.
//   clk, reset           : core clock, synchronous active-high reset
//   irq_in               : platform interrupt lines, rising edge requests
//   csr_en/cmd/addr/wdata: CSR access from the core; csr_rdata/csr_illegal combinational
//   trap_set/cause/pc    : trap entry; mret: trap return
//   irq_req/irq_cause    : arbitrated interrupt request to the control unit
//   trap_vector          : direct or vectored trap target from mtvec and trap_cause
//   mepc_out/mstatus_out : current mepc and mstatus
// Optional: define CSR_IRQ_CYCLE_EN to add the 64-bit mcycle counter at B00/B80.
module csr_irq_unit
   import csr_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = 4,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               csr_en,
   input  logic [2:0]         csr_cmd,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   output logic               csr_illegal,
   input  logic               trap_set,
   input  logic [31:0]        trap_cause,
   input  logic [31:0]        trap_pc,
   input  logic               mret,
   output logic               irq_req,
   output logic [31:0]        irq_cause,
   output logic [31:0]        trap_vector,
   output logic [31:0]        mepc_out,
   output logic [31:0]        mstatus_out
);

   localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
   localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

   logic               mie_bit_q, mie_bit_d;
   logic               mpie_bit_q, mpie_bit_d;
   logic [NUM_IRQ-1:0] irq_en_q, irq_en_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [31:0]        mtvec_q, mtvec_d;
   logic [31:0]        mepc_q, mepc_d;
   logic [31:0]        mcause_q, mcause_d;
   logic [31:0]        mscratch_q, mscratch_d;

   logic [31:0]        mstatus_w, mie_w, mip_w;
   logic               addr_legal;
   csr_op_e            op;
   logic               csr_we;
   logic [31:0]        csr_wval;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] ack_mask;
   logic               ack_hit;
   logic               arb_valid;
   logic [3:0]         arb_index;
   logic [31:0]        tvec_base;

`ifdef CSR_IRQ_CYCLE_EN
   logic [63:0]        mcycle_q, mcycle_d, mcycle_inc;
`endif

   // Architectural views of the sparse registers
   always_comb begin
      mstatus_w               = MSTATUS_MPP_BITS;
      mstatus_w[MSTATUS_MIE]  = mie_bit_q;
      mstatus_w[MSTATUS_MPIE] = mpie_bit_q;
      mie_w                   = '0;
      mie_w[IRQ_BIT_BASE +: NUM_IRQ] = irq_en_q;
      mip_w                   = '0;
      mip_w[IRQ_BIT_BASE +: NUM_IRQ] = pend_q;
   end

   // Read mux; an unknown address reads zero and is flagged illegal
   always_comb begin
      csr_rdata  = '0;
      addr_legal = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:  csr_rdata = mstatus_w;
         CSR_MIE:      csr_rdata = mie_w;
         CSR_MTVEC:    csr_rdata = mtvec_q;
         CSR_MSCRATCH: csr_rdata = mscratch_q;
         CSR_MEPC:     csr_rdata = mepc_q;
         CSR_MCAUSE:   csr_rdata = mcause_q;
         CSR_MIP:      csr_rdata = mip_w;
`ifdef CSR_IRQ_CYCLE_EN
         CSR_MCYCLE:   csr_rdata = mcycle_q[31:0];
         CSR_MCYCLEH:  csr_rdata = mcycle_q[63:32];
`endif
         default:      addr_legal = 1'b0;
      endcase
   end

   assign csr_illegal = csr_en & ~addr_legal;
   assign op          = decode_op(csr_cmd);

   // Set/clear with a zero operand is a pure read; trap and mret pre-empt CSR writes
   always_comb begin
      csr_we = csr_en & addr_legal & ~trap_set & ~mret &
               ((op == CsrOpWrite) |
                (((op == CsrOpSet) | (op == CsrOpClear)) & (|csr_wdata)));
      case (op)
         CsrOpWrite: csr_wval = csr_wdata;
         CsrOpSet:   csr_wval = csr_rdata | csr_wdata;
         CsrOpClear: csr_wval = csr_rdata & ~csr_wdata;
         default:    csr_wval = csr_rdata;
      endcase
   end

   assign rise = irq_in & ~irq_prev_q;

   // Trap entry on an external interrupt acknowledges that line's pending bit
   always_comb begin
      ack_hit  = trap_set & trap_cause[31] & trap_cause[4] & (32'(trap_cause[3:0]) < NUM_IRQ);
      ack_mask = '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         ack_mask[i] = ack_hit & (trap_cause[3:0] == 4'(i));
      end
   end

   always_comb begin
      mie_bit_d  = mie_bit_q;
      mpie_bit_d = mpie_bit_q;
      irq_en_d   = irq_en_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mscratch_d = mscratch_q;
      pend_d     = pend_q & ~ack_mask;

      if (trap_set) begin
         mepc_d     = trap_pc & MEPC_MASK;
         mcause_d   = trap_cause;
         mpie_bit_d = mie_bit_q;
         mie_bit_d  = 1'b0;
      end else if (mret) begin
         mie_bit_d  = mpie_bit_q;
         mpie_bit_d = 1'b1;
      end else if (csr_we) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mie_bit_d  = csr_wval[MSTATUS_MIE];
               mpie_bit_d = csr_wval[MSTATUS_MPIE];
            end
            CSR_MIE:      irq_en_d   = csr_wval[IRQ_BIT_BASE +: NUM_IRQ];
            CSR_MIP:      pend_d     = csr_wval[IRQ_BIT_BASE +: NUM_IRQ];
            CSR_MTVEC:    mtvec_d    = csr_wval & MTVEC_MASK;
            CSR_MEPC:     mepc_d     = csr_wval & MEPC_MASK;
            CSR_MCAUSE:   mcause_d   = csr_wval;
            CSR_MSCRATCH: mscratch_d = csr_wval;
            default: ;
         endcase
      end

      // A new edge always wins over any clear in the same cycle
      pend_d = pend_d | rise;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mie_bit_q  <= 1'b0;
         mpie_bit_q <= 1'b0;
         irq_en_q   <= '0;
         pend_q     <= '0;
         irq_prev_q <= '0;
         mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mscratch_q <= '0;
      end else begin
         mie_bit_q  <= mie_bit_d;
         mpie_bit_q <= mpie_bit_d;
         irq_en_q   <= irq_en_d;
         pend_q     <= pend_d;
         irq_prev_q <= irq_in;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mscratch_q <= mscratch_d;
      end
   end

`ifdef CSR_IRQ_CYCLE_EN
   // A write replaces the increment of the written half only; writing the low
   // half suppresses the carry into the high half for that cycle.
   always_comb begin
      mcycle_inc = mcycle_q + 64'd1;
      mcycle_d   = mcycle_inc;
      if (csr_we && (csr_addr == CSR_MCYCLE)) begin
         mcycle_d = {mcycle_q[63:32], csr_wval};
      end else if (csr_we && (csr_addr == CSR_MCYCLEH)) begin
         mcycle_d = {csr_wval, mcycle_inc[31:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcycle_q <= '0;
      end else begin
         mcycle_q <= mcycle_d;
      end
   end
`endif

   irq_arbiter #(
      .NUM_IRQ (NUM_IRQ)
   ) u_irq_arbiter (
      .active (pend_q & irq_en_q),
      .valid  (arb_valid),
      .index  (arb_index)
   );

   assign irq_req   = arb_valid & mie_bit_q;
   assign irq_cause = arb_valid ? (CAUSE_INTR_MSB | (32'(IRQ_BIT_BASE) + {28'b0, arb_index}))
                                : 32'h0;

   assign tvec_base   = {mtvec_q[31:2], 2'b00};
   assign trap_vector = (mtvec_q[0] & trap_cause[31]) ?
                        tvec_base + {25'b0, trap_cause[4:0], 2'b00} : tvec_base;

   assign mepc_out    = mepc_q;
   assign mstatus_out = mstatus_w;

endmodule

// File: tb/tb_csr_irq_unit.sv
// tb_csr_irq_unit: scoreboard bench for csr_irq_unit. The driver applies one set of inputs per
// cycle, queues the outputs a CSR-map reference model predicts, and a monitor compares them.
module tb_csr_irq_unit;

   localparam int unsigned NIRQ     = 4;
   localparam logic [31:0] TVEC_RST = 32'h0000_0100;

   logic            clk = 1'b0;
   logic            reset;
   logic [NIRQ-1:0] irq_in;
   logic            csr_en;
   logic [2:0]      csr_cmd;
   logic [11:0]     csr_addr;
   logic [31:0]     csr_wdata;
   logic [31:0]     csr_rdata;
   logic            csr_illegal;
   logic            trap_set;
   logic [31:0]     trap_cause;
   logic [31:0]     trap_pc;
   logic            mret;
   logic            irq_req;
   logic [31:0]     irq_cause;
   logic [31:0]     trap_vector;
   logic [31:0]     mepc_out;
   logic [31:0]     mstatus_out;

   always #5 clk = ~clk;

   csr_irq_unit #(
      .NUM_IRQ     (NIRQ),
      .MTVEC_RESET (TVEC_RST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .csr_en      (csr_en),
      .csr_cmd     (csr_cmd),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .trap_set    (trap_set),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .mret        (mret),
      .irq_req     (irq_req),
      .irq_cause   (irq_cause),
      .trap_vector (trap_vector),
      .mepc_out    (mepc_out),
      .mstatus_out (mstatus_out)
   );

   typedef struct {
      bit [31:0] rdata;
      bit        illegal;
      bit        req;
      bit [31:0] cause;
      bit [31:0] vec;
      bit [31:0] mepc;
      bit [31:0] mstatus;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: the CSR map as address -> value plus a write mask per address
   bit [31:0]       regs[int];
   bit [31:0]       wmask[int];
   bit [NIRQ-1:0]   prev;
   bit              model_ok = 1'b0;
   localparam bit [31:0] IRQ_BITS = ((32'h1 << NIRQ) - 1) << 16;

   function automatic void model_reset();
      regs.delete();
      wmask.delete();
      regs['h300] = 32'h0000_1800; wmask['h300] = 32'h0000_0088;
      regs['h304] = 0;             wmask['h304] = IRQ_BITS;
      regs['h305] = TVEC_RST;      wmask['h305] = 32'hFFFF_FFFD;
      regs['h340] = 0;             wmask['h340] = 32'hFFFF_FFFF;
      regs['h341] = 0;             wmask['h341] = 32'hFFFF_FFFC;
      regs['h342] = 0;             wmask['h342] = 32'hFFFF_FFFF;
      regs['h344] = 0;             wmask['h344] = IRQ_BITS;
`ifdef CSR_IRQ_CYCLE_EN
      regs['hB00] = 0;             wmask['hB00] = 32'hFFFF_FFFF;
      regs['hB80] = 0;             wmask['hB80] = 32'hFFFF_FFFF;
`endif
      prev = '0;
   endfunction

   function automatic void chk(string name, logic [31:0] got, bit [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
      end
   endfunction

   task automatic step(input bit rst, input bit [NIRQ-1:0] irq, input bit en, input bit [2:0] cmd,
                       input bit [11:0] addr, input bit [31:0] wd, input bit ts,
                       input bit [31:0] tc, input bit [31:0] tp, input bit mr);
      exp_t      e;
      bit        legal, wr;
      bit [31:0] active, st, nv, tv, old_lo, old_hi;
      int        a;
      @(negedge clk);
      reset = rst; irq_in = irq; csr_en = en; csr_cmd = cmd; csr_addr = addr;
      csr_wdata = wd; trap_set = ts; trap_cause = tc; trap_pc = tp; mret = mr;
      a     = int'(addr);
      legal = model_ok && regs.exists(a);
      if (model_ok) begin
         e.rdata   = legal ? regs[a] : 32'h0;
         e.illegal = en && !legal;
         active    = regs['h344] & regs['h304];
         e.cause   = 0;
         for (int i = 0; i < int'(NIRQ); i++) begin
            if (active[16 + i] && e.cause == 0) e.cause = 32'h8000_0000 | (16 + i);
         end
         st        = regs['h300];
         e.req     = (active != 0) && st[3];
         tv        = regs['h305];
         e.vec     = (tv[0] && tc[31]) ? (tv & ~32'h3) + 4 * tc[4:0] : (tv & ~32'h3);
         e.mepc    = regs['h341];
         e.mstatus = st;
         exp_q.push_back(e);
      end
      if (rst) begin
         model_reset();
         model_ok = 1'b1;
      end else if (model_ok) begin
         old_lo = regs.exists('hB00) ? regs['hB00] : 0;
         old_hi = regs.exists('hB80) ? regs['hB80] : 0;
         wr = 1'b0;
         if (ts) begin
            regs['h341] = tp & 32'hFFFF_FFFC;
            regs['h342] = tc;
            st = regs['h300];
            st[7] = st[3];
            st[3] = 1'b0;
            regs['h300] = st;
            if (tc[31] && tc[4:0] >= 16 && tc[4:0] - 16 < NIRQ)
               regs['h344] = regs['h344] & ~(32'h1 << tc[4:0]);
         end else if (mr) begin
            st = regs['h300];
            st[3] = st[7];
            st[7] = 1'b1;
            regs['h300] = st;
         end else if (en && legal) begin
            nv = regs[a];
            if (cmd inside {3'd1, 3'd5}) begin
               nv = wd; wr = 1'b1;
            end else if (cmd inside {3'd2, 3'd6} && wd != 0) begin
               nv = nv | wd; wr = 1'b1;
            end else if (cmd inside {3'd3, 3'd7} && wd != 0) begin
               nv = nv & ~wd; wr = 1'b1;
            end
            if (wr) regs[a] = (regs[a] & ~wmask[a]) | (nv & wmask[a]);
         end
         for (int i = 0; i < int'(NIRQ); i++) begin
            if (irq[i] && !prev[i]) regs['h344] = regs['h344] | (32'h1 << (16 + i));
         end
         prev = irq;
`ifdef CSR_IRQ_CYCLE_EN
         if (wr && a == 'hB00) regs['hB80] = old_hi;
         else if (wr && a == 'hB80) regs['hB00] = old_lo + 1;
         else {regs['hB80], regs['hB00]} = {old_hi, old_lo} + 64'd1;
`endif
      end
   endtask

   task automatic idle(input bit [11:0] addr, input bit [31:0] tc, input bit [NIRQ-1:0] irq);
      step(0, irq, 0, 3'd2, addr, 0, 0, tc, 0, 0);
   endtask

   // Monitor: samples between the driving edge and the active edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("csr_rdata", csr_rdata, e.rdata);
            chk("csr_illegal", {31'b0, csr_illegal}, {31'b0, e.illegal});
            chk("irq_req", {31'b0, irq_req}, {31'b0, e.req});
            chk("irq_cause", irq_cause, e.cause);
            chk("trap_vector", trap_vector, e.vec);
            chk("mepc_out", mepc_out, e.mepc);
            chk("mstatus_out", mstatus_out, e.mstatus);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [11:0]     alist[10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h344, 12'h7C0, 12'hB00, 12'hB80};
      bit [2:0]      clist[6]  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
      bit [NIRQ-1:0] irq_st = '0;
      bit [31:0]     wd, tc;

      reset = 1'b1; irq_in = '0; csr_en = 0; csr_cmd = 0; csr_addr = 0; csr_wdata = 0;
      trap_set = 0; trap_cause = 0; trap_pc = 0; mret = 0;

      // Reset for two cycles, then read back mstatus, mtvec and mip
      step(1, 0, 0, 3'd2, 12'h344, 0, 0, 0, 0, 0);
      step(1, 0, 0, 3'd2, 12'h344, 0, 0, 0, 0, 0);
      idle(12'h300, 0, 0);
      idle(12'h305, 0, 0);
      idle(12'h344, 0, 0);

      // Enable line 1 and global MIE, then pulse it
      step(0, 0, 1, 3'd2, 12'h304, 32'h0002_0000, 0, 0, 0, 0);
      step(0, 0, 1, 3'd6, 12'h300, 32'h0000_0008, 0, 0, 0, 0);
      idle(12'h344, 0, 4'b0010);
      idle(12'h344, 0, 4'b0000);
      idle(12'h344, 0, 4'b0000);

      // Trap entry acknowledges line 1
      step(0, 0, 0, 3'd2, 12'h344, 0, 1, 32'h8000_0011, 32'h0000_0104, 0);
      idle(12'h344, 0, 0);
      idle(12'h341, 0, 0);

      // Vectored mode, lines 0 and 2 both pending and enabled
      step(0, 0, 1, 3'd1, 12'h305, 32'h0000_1001, 0, 0, 0, 0);
      step(0, 0, 1, 3'd2, 12'h304, 32'h0005_0000, 0, 0, 0, 0);
      idle(12'h344, 0, 4'b0101);
      idle(12'h344, 32'h8000_0010, 4'b0000);
      idle(12'h305, 32'h8000_0012, 4'b0000);
      idle(12'h305, 32'h0000_0005, 4'b0000);

      // Clear bit 16 in the same cycle as a fresh rise on line 0; set with zero operand
      step(0, 4'b0001, 1, 3'd3, 12'h344, 32'h0001_0000, 0, 0, 0, 0);
      idle(12'h344, 0, 4'b0001);
      step(0, 4'b0001, 1, 3'd2, 12'h344, 32'h0000_0000, 0, 0, 0, 0);
      idle(12'h344, 0, 4'b0000);

      // mret restores MIE; illegal address leaves everything alone
      step(0, 0, 0, 3'd2, 12'h300, 0, 0, 0, 0, 1);
      idle(12'h300, 0, 0);
      step(0, 0, 1, 3'd1, 12'h7C0, 32'hFFFF_FFFF, 0, 0, 0, 0);
      step(0, 0, 1, 3'd1, 12'h7C0, 32'hFFFF_FFFF, 1, 32'h8000_0010, 32'h0000_0200, 1);
      idle(12'h344, 0, 0);

      // Randomised traffic
      for (int n = 0; n < 4000; n++) begin
         irq_st = irq_st ^ NIRQ'($urandom & $urandom & $urandom);
         case ($urandom_range(0, 3))
            0:       wd = 0;
            1:       wd = $urandom & 32'h000F_0088;
            2:       wd = $urandom;
            default: wd = $urandom & 32'h0000_1F0F;
         endcase
         case ($urandom_range(0, 2))
            0:       tc = 32'h8000_0000 | (16 + $urandom_range(0, 5));
            1:       tc = $urandom_range(0, 15);
            default: tc = $urandom;
         endcase
         step($urandom_range(0, 299) == 0, irq_st, $urandom_range(0, 1) == 1,
              clist[$urandom_range(0, 5)], alist[$urandom_range(0, 9)], wd,
              $urandom_range(0, 11) == 0, tc, $urandom, $urandom_range(0, 11) == 0);
      end

      @(negedge clk);
      #3;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/csr_irq_unit.md
Name: csr_irq_unit

Overview:
Parametrised machine-mode CSR file with a multi-line interrupt controller for the single-cycle RV32 core.
- Holds mstatus, mie, mip, mtvec, mepc, mcause and mscratch.
- Latches edge-triggered requests from NUM_IRQ platform lines and arbitrates them into one request plus cause for the control unit.
- Computes direct or vectored trap targets and performs trap entry and mret state updates.

Parameters:
NUM_IRQ, 4, number of platform interrupt lines; legal range 1..16; line i maps to mip/mie bit 16+i.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
clk  input  1  core clock
reset  input  1  synchronous reset, active-high
irq_in  input  NUM_IRQ  interrupt lines; synchronous to clk; a rising edge requests an interrupt
csr_en  input  1  current instruction is a CSR op
csr_cmd  input  3  funct3: 001/101 = RW, 010/110 = RS, 011/111 = RC; for immediate forms the core supplies the zero-extended uimm on csr_wdata
csr_addr  input  12  CSR address
csr_wdata  input  32  rs1 value or uimm
csr_rdata  output  32  old CSR value, combinational
csr_illegal  output  1  csr_en asserted with an unimplemented address, combinational
trap_set  input  1  core enters a trap this cycle
trap_cause  input  32  cause to record in mcause
trap_pc  input  32  PC to record in mepc
mret  input  1  mret retires this cycle
irq_req  output  1  an enabled, pending interrupt exists and mstatus.MIE=1
irq_cause  output  32  cause of the winning line: 32'h8000_0000 | (16+i)
trap_vector  output  32  trap target address
mepc_out  output  32  mepc value
mstatus_out  output  32  mstatus value

Behaviour:
- Reset (sync, active-high), all values take effect the cycle after reset is sampled high:
  - mstatus=32'h0000_1800 (MPP=11); mtvec=MTVEC_RESET; all other CSRs, pending and edge registers = 0.
  - irq_req=0.
  - Reset asserted mid-operation discards any pending request.
- Edge detect: per line, irq_prev <= irq_in; rise_i = irq_in[i] & ~irq_prev[i]. The pending bit is set one cycle after the rise; level-high without a new edge does not re-set it.
- Arbitration (combinational from registers):
  - active = mip[16+:NUM_IRQ] & mie[16+:NUM_IRQ].
  - Lowest active index wins.
  - irq_req = |active & mstatus[3].
  - irq_cause = 0 when no line is active.
- Write priority per cycle, highest first:
  1. trap_set: mepc <= {trap_pc[31:2],2'b00}; mcause <= trap_cause; MPIE <= MIE; MIE <= 0. If trap_cause[31]=1 and trap_cause[4:0]=16+i, pending[i] is cleared (auto-ack).
  2. mret: MIE <= MPIE; MPIE <= 1.
  3. CSR write: a write occurs for RW, or for RS/RC with csr_wdata != 0. RS ORs, RC AND-NOTs.
- Simultaneous events:
  - A rise on line i sets pending[i] even when a trap clear or RC clear of the same bit occurs that cycle (set wins).
  - CSR writes are dropped when trap_set or mret is active.
  - trap_set and mret asserted together is a core bug; trap_set wins.
- Writable masks (other bits read as constant):
  - mstatus: bits 3 and 7 only; MPP reads 11.
  - mie: bits 16..16+NUM_IRQ-1.
  - mip: same bits; software can set and clear pending bits.
  - mtvec: bits 31:2, plus bit 0 (mode); bit 1 reads 0.
  - mepc: bits 31:2.
  - mcause, mscratch: fully writable.
- Addresses: 300 mstatus, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 344 mip.
  - Any other address: csr_rdata=0, csr_illegal=1, no state change.
  - csr_illegal=0 when csr_en=0.
- trap_vector:
  - base = {mtvec[31:2],2'b00}.
  - If mtvec[0]=1 and trap_cause[31]=1: base + 4*trap_cause[4:0]; otherwise base.
  - Computed combinationally from trap_cause.

Optional Feature:
Macro CSR_IRQ_CYCLE_EN.
- Defined:
  - Adds a 64-bit mcycle counter that increments every cycle out of reset; reset value 0; wraps from 2^64-1 to 0.
  - Readable and writable at B00 (low half) and B80 (high half).
  - A CSR write replaces the increment in that cycle for the written half.
  - Write to B00 with low=FFFF_FFFF does not carry into the high half that cycle.
- Undefined: B00/B80 are illegal addresses.

Decomposition:
- Shared package csr_irq_pkg holds:
  - CSR address localparams.
  - funct3 command codes.
  - MSTATUS_MIE=3 and MSTATUS_MPIE=7.
  - IRQ_BIT_BASE=16.
  - CAUSE_INTR_MSB mask 32'h8000_0000.
- One sub-module, irq_arbiter (parametrised on NUM_IRQ): purely combinational priority encoder producing valid and index. Edge and pending registers stay in the top.

Test Plan:
- Reset: assert reset 2 cycles -> mstatus=0x1800, mtvec=MTVEC_RESET, irq_req=0, csr_rdata(mip)=0.
- Enable and fire: CSRRS mie 0x0002_0000, CSRRS mstatus 0x8, pulse irq_in[1] -> irq_req=1 next cycle, irq_cause=0x8000_0011.
- Trap entry: then trap_set with cause 0x8000_0011, trap_pc=0x104 -> mepc=0x104, MIE=0, MPIE=1, mip bit17 cleared, irq_req=0.
- Vectored and priority: mtvec=0x1001, lines 0 and 2 pending and enabled -> irq_cause=0x8000_0010, trap_vector=0x1040.
- Simultaneous set and clear: CSRRC mip 0x0001_0000 in the same cycle as a rise on irq_in[0] -> bit16 stays 1; CSRRS mip with wdata=0 -> no change.
- mret and illegal: mret -> MIE=1, MPIE=1; csr_en with addr 0x7C0 -> csr_illegal=1, csr_rdata=0, all CSRs unchanged.
